// File: rtl/cmos_frame_packer.sv
// Crops a window out of a CMOS pixel stream, converts RGB888 to RGB565 and packs
// two pixels per 32-bit FIFO word, with frame start/done/error reporting.
module cmos_frame_packer #(
    parameter int H_START = 0,
    parameter int V_START = 0,
    parameter int H_SIZE  = 640,
    parameter int V_SIZE  = 480
) (
    input  logic        cmos_pclk,
    input  logic        rst_n,
    input  logic        capture_en,
    input  logic        pix_vsync,
    input  logic        pix_href,
    input  logic        pix_ce,
    input  logic [23:0] pix_data,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [31:0] fifo_wr_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic        frame_err,
    output logic        overflow,
    output logic [15:0] frame_cnt
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] DROP    = 2'd3;

    localparam logic [15:0] H_START_C = 16'(H_START);
    localparam logic [15:0] V_START_C = 16'(V_START);
    localparam logic [15:0] H_SIZE_C  = 16'(H_SIZE);
    localparam logic [15:0] V_SIZE_C  = 16'(V_SIZE);
    localparam logic [15:0] V_LAST_C  = 16'(V_START + V_SIZE - 1);

    logic [1:0]  state_q, state_d;
    logic        vsync_q, vsync_d;
    logic        href_q, href_d;
    logic [15:0] col_q, col_d;
    logic [15:0] line_q, line_d;
    logic [15:0] hold_q, hold_d;
    logic        held_q, held_d;
    logic        done_pend_q, done_pend_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        start_q, start_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        ovf_q, ovf_d;
    logic [15:0] cnt_q, cnt_d;

    logic        vsync_rise, href_rise, href_fall, pix_accept, in_win;
    logic [15:0] col_eff, col_off, line_off, px565;
    logic        write_req;
    logic [31:0] write_word;
    logic        unused_pix_bits;

    assign vsync_rise = pix_vsync & ~vsync_q;
    assign href_rise  = pix_href & ~href_q;
    assign href_fall  = ~pix_href & href_q;
    assign pix_accept = pix_ce & pix_href;

    // A pixel arriving on the href rise cycle is column 0 of the new line.
    assign col_eff  = href_rise ? 16'd0 : col_q;
    // Offsets wrap below the window start, so a single unsigned compare covers both bounds.
    assign col_off  = col_eff - H_START_C;
    assign line_off = line_q - V_START_C;
    assign in_win   = (col_off < H_SIZE_C) && (line_off < V_SIZE_C);
    assign px565    = {pix_data[23:19], pix_data[15:10], pix_data[7:3]};
    assign unused_pix_bits = ^{pix_data[18:16], pix_data[9:8], pix_data[2:0]};

    always_comb begin
        vsync_d     = pix_vsync;
        href_d      = pix_href;
        state_d     = state_q;
        col_d       = col_q;
        line_d      = line_q;
        hold_d      = hold_q;
        held_d      = held_q;
        done_pend_d = 1'b0;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;
        start_d     = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        write_req   = 1'b0;
        write_word  = 32'd0;

        // Deferred completion after a final unpaired word was flushed.
        if (done_pend_q) begin
            done_d = 1'b1;
            cnt_d  = cnt_q + 16'd1;
        end

        case (state_q)
            IDLE, DROP: begin
                if (vsync_rise) begin
                    col_d  = 16'd0;
                    line_d = 16'd0;
                    held_d = 1'b0;
                    if (capture_en) begin
                        state_d = ARMED;
                        start_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                if (vsync_rise) begin
                    err_d  = 1'b1;
                    col_d  = 16'd0;
                    line_d = 16'd0;
                    held_d = 1'b0;
                    if (capture_en) begin
                        state_d = ARMED;
                        start_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if ((state_q == CAPTURE) || href_rise) begin
                    state_d = CAPTURE;
                    col_d   = col_eff;
                    if (pix_accept) begin
                        col_d = col_eff + 16'd1;
                        if (in_win) begin
                            if (!held_q) begin
                                hold_d = px565;
                                held_d = 1'b1;
                            end else begin
                                write_req  = 1'b1;
                                write_word = {px565, hold_q};
                            end
                        end
                    end
                    if (href_fall) begin
                        line_d = line_q + 16'd1;
                        if (held_q) begin
                            write_req  = 1'b1;
                            write_word = {16'd0, hold_q};
                        end
                        if (line_q == V_LAST_C) begin
                            state_d = IDLE;
                            if (held_q) begin
                                done_pend_d = 1'b1;
                            end else begin
                                done_d = 1'b1;
                                cnt_d  = cnt_q + 16'd1;
                            end
                        end
                    end
                    if (write_req) begin
                        held_d = 1'b0;
                        if (fifo_full) begin
                            ovf_d       = 1'b1;
                            err_d       = 1'b1;
                            state_d     = DROP;
                            done_d      = done_pend_q;
                            cnt_d       = done_pend_q ? cnt_q + 16'd1 : cnt_q;
                            done_pend_d = 1'b0;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_data_d = write_word;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            col_q       <= 16'd0;
            line_q      <= 16'd0;
            hold_q      <= 16'd0;
            held_q      <= 1'b0;
            done_pend_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= 32'd0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            col_q       <= col_d;
            line_q      <= line_d;
            hold_q      <= hold_d;
            held_q      <= held_d;
            done_pend_q <= done_pend_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            start_q     <= start_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign frame_start  = start_q;
    assign frame_done   = done_q;
    assign frame_err    = err_q;
    assign overflow     = ovf_q;
    assign frame_cnt    = cnt_q;

endmodule

// File: tb/tb_cmos_frame_packer.sv
// Directed bench for cmos_frame_packer with a 4x2 crop window at column 2, line 1.
module tb_cmos_frame_packer;

    logic        cmos_pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        capture_en = 1'b0;
    logic        pix_vsync = 1'b0;
    logic        pix_href = 1'b0;
    logic        pix_ce = 1'b0;
    logic [23:0] pix_data = 24'd0;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_data;
    logic        frame_start;
    logic        frame_done;
    logic        frame_err;
    logic        overflow;
    logic [15:0] frame_cnt;

    cmos_frame_packer #(
        .H_START(2),
        .V_START(1),
        .H_SIZE (4),
        .V_SIZE (2)
    ) dut (
        .cmos_pclk   (cmos_pclk),
        .rst_n       (rst_n),
        .capture_en  (capture_en),
        .pix_vsync   (pix_vsync),
        .pix_href    (pix_href),
        .pix_ce      (pix_ce),
        .pix_data    (pix_data),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .overflow    (overflow),
        .frame_cnt   (frame_cnt)
    );

    always #5 cmos_pclk = ~cmos_pclk;

    int          n_vec = 0;
    int          n_miss = 0;
    int          cyc = 0;
    logic [31:0] wlog[$];
    int          n_start = 0;
    int          n_done = 0;
    int          n_err = 0;
    int          last_wr_cyc = 0;
    int          done_cyc = 0;

    always @(posedge cmos_pclk) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle.
    always @(negedge cmos_pclk) begin
        if (fifo_wr_en) begin
            wlog.push_back(fifo_wr_data);
            last_wr_cyc <= cyc;
        end
        if (frame_start) n_start <= n_start + 1;
        if (frame_done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (frame_err) n_err <= n_err + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic [31:0] word_at(input int idx);
        if (idx < wlog.size()) return wlog[idx];
        return 32'hDEADBEEF;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge cmos_pclk);
            #1;
        end
    endtask

    task automatic vsync_pulse();
        pix_vsync = 1'b1;
        tick(2);
        pix_vsync = 1'b0;
        tick(2);
    endtask

    // mode 0: constant 0xF8FC00; mode 1: each byte = column[2:0] << 5
    function automatic logic [23:0] pixval(input int mode, input int c);
        logic [2:0] c3;
        c3 = c[2:0];
        if (mode == 0) return 24'hF8FC00;
        return {c3, 5'b0, c3, 5'b0, c3, 5'b0};
    endfunction

    task automatic send_line(input int npix, input int mode, input int full_at);
        pix_href = 1'b1;
        for (int i = 0; i < npix; i++) begin
            pix_ce    = 1'b1;
            pix_data  = pixval(mode, i);
            fifo_full = (full_at >= 0) && ((i == full_at) || (i == full_at + 1));
            tick(1);
        end
        pix_href  = 1'b0;
        pix_ce    = 1'b0;
        fifo_full = 1'b0;
        tick(3);
    endtask

    task automatic send_frame(input int mode, input int full_at);
        for (int l = 0; l < 3; l++) send_line(8, mode, (l == 1) ? full_at : -1);
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_wr_en"}, {31'd0, fifo_wr_en}, 32'd0);
        chk({pfx, "_wr_data"}, fifo_wr_data, 32'd0);
        chk({pfx, "_start"}, {31'd0, frame_start}, 32'd0);
        chk({pfx, "_done"}, {31'd0, frame_done}, 32'd0);
        chk({pfx, "_err"}, {31'd0, frame_err}, 32'd0);
        chk({pfx, "_overflow"}, {31'd0, overflow}, 32'd0);
        chk({pfx, "_frame_cnt"}, {16'd0, frame_cnt}, 32'd0);
    endtask

    initial begin
        int b, s0, d0, e0;

        tick(3);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        tick(2);

        // Constant colour frame
        capture_en = 1'b1;
        b = wlog.size(); s0 = n_start; d0 = n_done; e0 = n_err;
        vsync_pulse();
        send_frame(0, -1);
        tick(3);
        chk("A_writes", 32'(wlog.size() - b), 32'd4);
        for (int i = 0; i < 4; i++) chk("A_word", word_at(b + i), 32'hFFE0FFE0);
        chk("A_start", 32'(n_start - s0), 32'd1);
        chk("A_done", 32'(n_done - d0), 32'd1);
        chk("A_err", 32'(n_err - e0), 32'd0);
        chk("A_done_after_wr", {31'd0, done_cyc > last_wr_cyc}, 32'd1);
        chk("A_frame_cnt", {16'd0, frame_cnt}, 32'd1);

        // Column-indexed pixels
        b = wlog.size(); d0 = n_done;
        vsync_pulse();
        send_frame(1, -1);
        tick(3);
        chk("B_writes", 32'(wlog.size() - b), 32'd4);
        chk("B_word0", word_at(b + 0), 32'h630C4208);
        chk("B_word1", word_at(b + 1), 32'hA5148410);
        chk("B_word2", word_at(b + 2), 32'h630C4208);
        chk("B_word3", word_at(b + 3), 32'hA5148410);
        chk("B_done", 32'(n_done - d0), 32'd1);
        chk("B_frame_cnt", {16'd0, frame_cnt}, 32'd2);

        // FIFO full on the second write of the frame
        b = wlog.size(); d0 = n_done; e0 = n_err;
        vsync_pulse();
        send_frame(0, 5);
        tick(3);
        chk("C_writes", 32'(wlog.size() - b), 32'd1);
        chk("C_word0", word_at(b), 32'hFFE0FFE0);
        chk("C_overflow", {31'd0, overflow}, 32'd1);
        chk("C_err", 32'(n_err - e0), 32'd1);
        chk("C_done", 32'(n_done - d0), 32'd0);
        chk("C_frame_cnt", {16'd0, frame_cnt}, 32'd2);

        rst_n = 1'b0;
        tick(2);
        chk("R_overflow", {31'd0, overflow}, 32'd0);
        chk("R_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // vsync restart after line 1
        b = wlog.size(); s0 = n_start; d0 = n_done; e0 = n_err;
        vsync_pulse();
        send_line(8, 0, -1);
        send_line(8, 0, -1);
        chk("D_partial_writes", 32'(wlog.size() - b), 32'd2);
        vsync_pulse();
        send_frame(0, -1);
        tick(3);
        chk("D_writes", 32'(wlog.size() - b), 32'd6);
        chk("D_err", 32'(n_err - e0), 32'd1);
        chk("D_start", 32'(n_start - s0), 32'd2);
        chk("D_done", 32'(n_done - d0), 32'd1);
        chk("D_frame_cnt", {16'd0, frame_cnt}, 32'd1);

        // Short line leaves an unpaired pixel
        b = wlog.size(); d0 = n_done;
        vsync_pulse();
        send_line(8, 1, -1);
        send_line(3, 1, -1);
        send_line(8, 1, -1);
        tick(3);
        chk("E_writes", 32'(wlog.size() - b), 32'd3);
        chk("E_word0", word_at(b + 0), 32'h00004208);
        chk("E_word1", word_at(b + 1), 32'h630C4208);
        chk("E_word2", word_at(b + 2), 32'hA5148410);
        chk("E_done", 32'(n_done - d0), 32'd1);
        chk("E_frame_cnt", {16'd0, frame_cnt}, 32'd2);

        // Capture disabled at vsync
        capture_en = 1'b0;
        b = wlog.size(); s0 = n_start; d0 = n_done; e0 = n_err;
        vsync_pulse();
        send_frame(1, -1);
        tick(3);
        chk("F_off_writes", 32'(wlog.size() - b), 32'd0);
        chk("F_off_pulses", 32'((n_start - s0) + (n_done - d0) + (n_err - e0)), 32'd0);

        // Reset mid-line
        capture_en = 1'b1;
        b = wlog.size();
        vsync_pulse();
        send_line(8, 1, -1);
        pix_href = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pix_ce   = 1'b1;
            pix_data = pixval(1, i);
            tick(1);
        end
        tick(0);
        #4;
        chk("F_pre_rst_writes", 32'(wlog.size() - b), 32'd1);
        chk("F_pre_rst_word", word_at(b), 32'h630C4208);
        b = wlog.size(); d0 = n_done;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("F_rst");
        for (int i = 5; i < 8; i++) begin
            pix_data = pixval(1, i);
            tick(1);
        end
        rst_n = 1'b1;
        tick(1);
        pix_href = 1'b0;
        pix_ce   = 1'b0;
        tick(3);
        send_line(8, 1, -1);
        tick(3);
        chk("F_post_rst_writes", 32'(wlog.size() - b), 32'd0);
        chk("F_post_rst_done", 32'(n_done - d0), 32'd0);
        chk("F_post_rst_cnt", {16'd0, frame_cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
